bitfusion_dot_ctrl: RTL
=======================

Name: bitfusion_dot_ctrl

Overview:
Job sequencer for the 4-bit fused BitFusion multiplier (in/weight 4b, widths 1/2/4, per-operand sign, 8-bit psum). It accepts one dot-product job (length, widths, signedness) and streams operand pairs into the multiplier. It drives the multiplier's configuration, masks operands to their width, and accumulates the sign- or zero-extended psums. The final sum is returned over a valid/ready result port. It sits between the operand buffers and the fused multiplier.

Parameters:
ACC_W, 16, accumulator/result width (>=9)
MUL_LATENCY, 1, edges from pe_in/pe_weight update to pe_psum capture (1..4)

Ports:
CLK_125MHZ_FPGA  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  job request
cfg_ready  output  1  high only in IDLE
cfg_len  input  8  number of operand pairs (0 allowed)
cfg_in_width  input  3  input width: 1, 2 or 4
cfg_weight_width  input  3  weight width: 1, 2 or 4
cfg_s_in  input  1  input signed
cfg_s_weight  input  1  weight signed
op_valid  input  1  operand pair valid
op_ready  output  1  controller can accept a pair
op_in  input  4  input operand (low in_width bits significant)
op_weight  input  4  weight operand
pe_in  output  4  to multiplier in
pe_weight  output  4  to multiplier weight
pe_in_width  output  3  to multiplier in_width
pe_weight_width  output  3  to multiplier weight_width
pe_s_in  output  1  to multiplier s_in
pe_s_weight  output  1  to multiplier s_weight
pe_psum  input  8  multiplier product
res_valid  output  1  result available
res_ready  input  1  result consumed
res_data  output  ACC_W  accumulated sum (two's complement if any signed)
res_overflow  output  1  sticky accumulation overflow
res_err  output  1  job rejected (illegal width)

Behaviour:
- Reset (async): state IDLE. cfg_ready=1, op_ready=0, res_valid=0, res_data=0, res_overflow=0, res_err=0. pe_in=pe_weight=0, pe_in_width=pe_weight_width=4, pe_s_in=pe_s_weight=0. Issue/capture counters and latency tag pipe cleared. Reset mid-job discards the job and all in-flight products.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: a cfg_valid&cfg_ready edge latches the job; pe_* config updates on the same edge and stays stable until return to IDLE. Accumulator and flags clear.
  - Illegal width (not 1/2/4): go to DONE with res_err=1, res_data=0.
  - cfg_len=0: go to DONE with res_data=0, res_err=0.
  - Otherwise go to RUN.
- RUN: op_ready=1 while issued<len. On an op_valid&op_ready edge:
  - pe_in <= op_in masked to in_width LSBs (upper bits 0); same for pe_weight with weight_width.
  - issued++ and a tag enters the MUL_LATENCY-deep pipe.
  - pe_in/pe_weight hold their value when no pair is accepted.
  - The edge accepting pair #len moves to DRAIN; op_ready drops the next cycle.
- Capture: at edge k+MUL_LATENCY after accept edge k, the accumulator adds ext(pe_psum).
  - ext = 8-bit sign extension if s_in|s_weight, else zero extension.
  - Back-to-back accepts give one capture per cycle.
- Overflow: signed mode sets res_overflow on two's-complement add overflow; unsigned mode sets it on carry out of ACC_W. The result wraps modulo 2^ACC_W. res_overflow is sticky for the job.
- DRAIN: wait until captured==len, then go to DONE. The final capture edge and the DONE entry coincide, so res_valid rises the cycle after the last capture edge.
- DONE: res_valid=1. res_data and the flags are stable until res_ready. A res_valid&res_ready edge returns to IDLE, lowers res_valid and raises cfg_ready; no bubble is needed before the next cfg accept.
- cfg_valid outside IDLE is ignored (cfg_ready=0). op_valid outside RUN is ignored.

Test Plan:
- Unsigned 4x4, len=3, pairs (15,15),(3,5),(0,9) -> res_data=240, res_overflow=0, res_err=0; exactly 3 op handshakes.
- Signed 4x4, len=2, pairs (-8,-8),(7,-8) -> res_data=8; pe_s_in=pe_s_weight=1 throughout the job.
- in_width=2, weight_width=4, signed, pairs (-2,7),(1,-8), op_in driven 4'b1110 -> pe_in=4'b0010; res_data=16'hFFEA (-22).
- Backpressure: op_valid toggled every other cycle, res_ready low 5 cycles after res_valid -> sum unchanged; res_data stable; cfg_ready=0 until the result handshake.
- cfg_in_width=3 -> res_err=1, res_data=0, op_ready never asserted. cfg_len=0 -> res_data=0, res_err=0.
- ACC_W=12, unsigned, 20 x (15,15) -> res_overflow=1, res_data=404. Assert rst after the 5th pair of a repeat job -> all outputs return to reset values immediately; the next job is correct.

Source files
------------

// File: rtl/bitfusion_dot_ctrl.sv
// Dot-product job sequencer for the 4-bit fused BitFusion multiplier: streams masked
// operand pairs into the multiplier and accumulates extended partial sums.
module bitfusion_dot_ctrl #(
  parameter int ACC_W       = 16,
  parameter int MUL_LATENCY = 1
) (
  input  logic             CLK_125MHZ_FPGA,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_len,
  input  logic [2:0]       cfg_in_width,
  input  logic [2:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_in,
  input  logic [3:0]       op_weight,
  output logic [3:0]       pe_in,
  output logic [3:0]       pe_weight,
  output logic [2:0]       pe_in_width,
  output logic [2:0]       pe_weight_width,
  output logic             pe_s_in,
  output logic             pe_s_weight,
  input  logic [7:0]       pe_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_overflow,
  output logic             res_err
);

  // state | meaning
  // IDLE  | waiting for a job, cfg_ready high
  // RUN   | issuing operand pairs until len have been accepted
  // DRAIN | waiting for the in-flight products to be captured
  // DONE  | result held on res_* until res_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             len_q, issued_q, captured_q, captured_nxt;
  logic [MUL_LATENCY-1:0] tag_q;
  logic [ACC_W-1:0]       acc_q, psum_ext, sum;
  logic                   carry, cap, sgn, add_ovf;
  logic                   cfg_fire, op_fire, widths_ok;

  function automatic logic width_legal(input logic [2:0] w);
    return (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
  endfunction

  function automatic logic [3:0] mask_op(input logic [3:0] v, input logic [2:0] w);
    case (w)
      3'd1:    return {3'b000, v[0]};
      3'd2:    return {2'b00, v[1:0]};
      default: return v;
    endcase
  endfunction

  assign cfg_ready    = (state == S_IDLE);
  assign op_ready     = (state == S_RUN);
  assign res_valid    = (state == S_DONE);
  assign cfg_fire     = cfg_valid & cfg_ready;
  assign op_fire      = op_valid & op_ready;
  assign widths_ok    = width_legal(cfg_in_width) & width_legal(cfg_weight_width);
  assign cap          = tag_q[MUL_LATENCY-1];
  assign captured_nxt = captured_q + {7'd0, cap};

  // Products are sign-extended whenever either operand is signed.
  assign sgn      = pe_s_in | pe_s_weight;
  assign psum_ext = {{(ACC_W-8){sgn & pe_psum[7]}}, pe_psum};
  assign {carry, sum} = {1'b0, acc_q} + {1'b0, psum_ext};
  assign add_ovf  = sgn ? ((acc_q[ACC_W-1] == psum_ext[ACC_W-1]) &&
                           (sum[ACC_W-1] != acc_q[ACC_W-1]))
                        : carry;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_fire) begin
                 if (!widths_ok || cfg_len == 8'd0) state_nxt = S_DONE;
                 else                               state_nxt = S_RUN;
               end
      S_RUN:   if (op_fire && (issued_q + 8'd1 == len_q)) state_nxt = S_DRAIN;
      S_DRAIN: if (captured_nxt == len_q) state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_125MHZ_FPGA or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      captured_q      <= '0;
      tag_q           <= '0;
      acc_q           <= '0;
      res_overflow    <= 1'b0;
      res_err         <= 1'b0;
      pe_in           <= '0;
      pe_weight       <= '0;
      pe_in_width     <= 3'd4;
      pe_weight_width <= 3'd4;
      pe_s_in         <= 1'b0;
      pe_s_weight     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tag_q[0] <= op_fire;
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];

      if (cfg_fire) begin
        len_q           <= cfg_len;
        issued_q        <= '0;
        captured_q      <= '0;
        acc_q           <= '0;
        res_overflow    <= 1'b0;
        res_err         <= ~widths_ok;
        pe_in_width     <= cfg_in_width;
        pe_weight_width <= cfg_weight_width;
        pe_s_in         <= cfg_s_in;
        pe_s_weight     <= cfg_s_weight;
      end else begin
        if (op_fire) begin
          pe_in     <= mask_op(op_in, pe_in_width);
          pe_weight <= mask_op(op_weight, pe_weight_width);
          issued_q  <= issued_q + 8'd1;
        end
        if (cap) begin
          acc_q        <= sum;
          captured_q   <= captured_nxt;
          res_overflow <= res_overflow | add_ovf;
        end
      end
    end
  end

  assign res_data = acc_q;

endmodule
